// File: rtl/pm_boot_loader.sv
// Byte-stream program-memory loader: length header, 4N payload bytes, registered write port.
// Optional trailing XOR checksum stage enabled by defining PM_BOOT_CHECKSUM_EN.
module pm_boot_loader #(
    parameter int ADD_WIDTH = 7,
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req,
    input  logic [WIDTH-1:0]     byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 pm_wr_en,
    output logic [ADD_WIDTH-1:0] pm_addr,
    output logic [WIDTH-1:0]     pm_wr_data,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

`ifdef PM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_FLUSH, S_RUN, S_ERROR, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_FLUSH, S_RUN, S_ERROR} state_t;
`endif

    state_t               state, next_state;
    logic [ADD_WIDTH-1:0] byte_cnt;
    logic [ADD_WIDTH-1:0] last_idx;
    logic [WIDTH+1:0]     len_bytes;
    logic                 hdr_acc, data_acc, hdr_bad, last_byte;
`ifdef PM_BOOT_CHECKSUM_EN
    logic [WIDTH-1:0]     csum;
`endif

    assign len_bytes = {byte_in, 2'b00};
    assign hdr_bad   = (byte_in == '0) || (byte_in > WIDTH'(MAX_WORDS));
    assign last_byte = (byte_cnt == last_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        hdr_acc    = 1'b0;
        data_acc   = 1'b0;
        case (state)
            S_IDLE: if (load_req) next_state = S_HDR;
            S_HDR: begin
                byte_ready = 1'b1;
                hdr_acc    = byte_valid;
                if (byte_valid) next_state = hdr_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                data_acc   = byte_valid;
`ifdef PM_BOOT_CHECKSUM_EN
                if (byte_valid && last_byte) next_state = S_CHK;
`else
                if (byte_valid && last_byte) next_state = S_FLUSH;
`endif
            end
`ifdef PM_BOOT_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) next_state = (byte_in == csum) ? S_FLUSH : S_ERROR;
            end
`endif
            S_FLUSH: next_state = S_RUN;
            S_RUN: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (load_req) next_state = S_HDR;
            end
            S_ERROR: begin
                err = 1'b1;
                if (load_req) next_state = S_HDR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Write port is registered: the pulse for byte j appears the cycle after it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_wr_en   <= 1'b0;
            pm_addr    <= '0;
            pm_wr_data <= '0;
            byte_cnt   <= '0;
            last_idx   <= '0;
        end else begin
            pm_wr_en <= data_acc;
            if (data_acc) begin
                pm_addr    <= byte_cnt;
                pm_wr_data <= byte_in;
                if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
            end
            if (hdr_acc && !hdr_bad) begin
                last_idx <= ADD_WIDTH'(len_bytes - 1'b1);
                byte_cnt <= '0;
            end
        end
    end

`ifdef PM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    csum <= '0;
        else if (next_state == S_HDR && state != S_HDR) csum <= '0;
        else if (data_acc)                           csum <= csum ^ byte_in;
    end
`endif

endmodule
